rob_ctrl: RTL and testbench

//  Pointer and sequencing controller for the reorder buffer storage.
//  - Hands out ROB tickets (slot ids) to decode in order.
//  - Tracks per-slot completion and exception status from the two writeback ports (sp, lp).
//  - Retires the head entry in order to the register bank.
//  - On an exception at head, runs a handshake-then-flush sequence.

---
 rtl/rob_ctrl.sv | 164 ++++++++++++++++
 tb/tb_rob_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_ctrl.sv
// rtl/rob_ctrl.sv - reorder buffer pointer, completion and exception sequencing controller
//
// Purpose:
//   Hands out in-order ROB tickets, records per-slot done/exception state from
//   the short-pipe (sp) and long-pipe (lp) writeback ports, retires the head
//   entry in order, and on a faulting head runs an ack handshake followed by a
//   one-cycle flush that empties the ROB.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_alloc_req             decode wants a ticket
//   o_alloc_grant           ticket granted this cycle (combinational)
//   o_alloc_ticket          granted slot id (tail)
//   o_full, o_empty         occupancy flags
//   o_count                 occupied slot count
//   i_cmpl_sp_*/i_cmpl_lp_* completion strobe, slot id, exception flag
//   o_head_ptr              head slot id
//   o_commit_valid          head done without exception, may retire
//   i_commit_stall          register bank cannot retire this cycle
//   o_exc_valid, o_exc_slot faulting head presented until i_exc_ack
//   i_exc_ack               redirect logic accepted the exception
//   o_flush                 one-cycle pulse, ROB emptied at end of cycle
module rob_ctrl #(
  parameter int NUM_ENTRIES     = 8,
  parameter int LOG_NUM_ENTRIES = 3
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_alloc_req,
  output logic                       o_alloc_grant,
  output logic [LOG_NUM_ENTRIES-1:0] o_alloc_ticket,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [LOG_NUM_ENTRIES:0]   o_count,
  input  logic                       i_cmpl_sp_valid,
  input  logic [LOG_NUM_ENTRIES-1:0] i_cmpl_sp_slot,
  input  logic                       i_cmpl_sp_exc,
  input  logic                       i_cmpl_lp_valid,
  input  logic [LOG_NUM_ENTRIES-1:0] i_cmpl_lp_slot,
  input  logic                       i_cmpl_lp_exc,
  output logic [LOG_NUM_ENTRIES-1:0] o_head_ptr,
  output logic                       o_commit_valid,
  input  logic                       i_commit_stall,
  output logic                       o_exc_valid,
  output logic [LOG_NUM_ENTRIES-1:0] o_exc_slot,
  input  logic                       i_exc_ack,
  output logic                       o_flush
);

  localparam logic [LOG_NUM_ENTRIES-1:0] PTR_ONE  = 1;
  localparam logic [LOG_NUM_ENTRIES:0]   CNT_ONE  = 1;
  localparam logic [LOG_NUM_ENTRIES:0]   CNT_FULL = NUM_ENTRIES[LOG_NUM_ENTRIES:0];

  typedef enum logic [1:0] {ST_RUN, ST_EXC_WAIT, ST_FLUSH} state_t;

  state_t                     r_state;
  logic [LOG_NUM_ENTRIES-1:0] r_head;
  logic [LOG_NUM_ENTRIES-1:0] r_tail;
  logic [LOG_NUM_ENTRIES:0]   r_count;
  logic [NUM_ENTRIES-1:0]     r_done;
  logic [NUM_ENTRIES-1:0]     r_exc;

  logic                       w_run;
  logic [LOG_NUM_ENTRIES-1:0] w_sp_off;
  logic [LOG_NUM_ENTRIES-1:0] w_lp_off;
  logic                       w_sp_ok;
  logic                       w_lp_ok;
  logic                       w_retire;
  logic                       w_fault;
  logic [NUM_ENTRIES-1:0]     w_done_cmpl;
  logic [NUM_ENTRIES-1:0]     w_exc_cmpl;
  logic [NUM_ENTRIES-1:0]     w_done_nxt;
  logic [NUM_ENTRIES-1:0]     w_exc_nxt;

  assign w_run          = (r_state == ST_RUN);
  assign o_full         = (r_count == CNT_FULL);
  assign o_empty        = (r_count == '0);
  assign o_count        = r_count;
  assign o_alloc_ticket = r_tail;
  assign o_head_ptr     = r_head;
  // Head cannot move outside RUN, so the head pointer is the frozen faulting slot.
  assign o_exc_slot     = r_head;
  assign o_exc_valid    = (r_state == ST_EXC_WAIT);
  assign o_flush        = (r_state == ST_FLUSH);

  assign o_alloc_grant  = i_alloc_req & ~o_full & w_run;
  assign o_commit_valid = w_run & ~o_empty & r_done[r_head] & ~r_exc[r_head];
  assign w_retire       = o_commit_valid & ~i_commit_stall;

  // A slot is occupied when its distance from head is below the count;
  // this covers wrap-around and the full case where head == tail.
  assign w_sp_off = i_cmpl_sp_slot - r_head;
  assign w_lp_off = i_cmpl_lp_slot - r_head;
  assign w_sp_ok  = i_cmpl_sp_valid & w_run & ({1'b0, w_sp_off} < r_count);
  assign w_lp_ok  = i_cmpl_lp_valid & w_run & ({1'b0, w_lp_off} < r_count);

  always_comb begin
    w_done_cmpl = r_done;
    w_exc_cmpl  = r_exc;
    if (w_sp_ok) begin
      w_done_cmpl[i_cmpl_sp_slot] = 1'b1;
      w_exc_cmpl[i_cmpl_sp_slot]  = w_exc_cmpl[i_cmpl_sp_slot] | i_cmpl_sp_exc;
    end
    if (w_lp_ok) begin
      w_done_cmpl[i_cmpl_lp_slot] = 1'b1;
      w_exc_cmpl[i_cmpl_lp_slot]  = w_exc_cmpl[i_cmpl_lp_slot] | i_cmpl_lp_exc;
    end
  end

  // Retire and grant free/claim slots after completions land; the freed head
  // and the claimed tail never alias because retire needs count>0 and grant needs !full.
  always_comb begin
    w_done_nxt = w_done_cmpl;
    w_exc_nxt  = w_exc_cmpl;
    if (w_retire) begin
      w_done_nxt[r_head] = 1'b0;
      w_exc_nxt[r_head]  = 1'b0;
    end
    if (o_alloc_grant) begin
      w_done_nxt[r_tail] = 1'b0;
      w_exc_nxt[r_tail]  = 1'b0;
    end
  end

  // Looking at post-completion status lets a faulting completion reach
  // o_exc_valid on the following cycle, matching the commit latency.
  assign w_fault = w_run & ~o_empty & ~w_retire & w_done_cmpl[r_head] & w_exc_cmpl[r_head];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_RUN;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_done  <= '0;
      r_exc   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_done <= w_done_nxt;
          r_exc  <= w_exc_nxt;
          if (w_retire)      r_head <= r_head + PTR_ONE;
          if (o_alloc_grant) r_tail <= r_tail + PTR_ONE;
          if (o_alloc_grant && !w_retire)      r_count <= r_count + CNT_ONE;
          else if (!o_alloc_grant && w_retire) r_count <= r_count - CNT_ONE;
          if (w_fault) r_state <= ST_EXC_WAIT;
        end
        ST_EXC_WAIT: begin
          if (i_exc_ack) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          r_head  <= '0;
          r_tail  <= '0;
          r_count <= '0;
          r_done  <= '0;
          r_exc   <= '0;
          r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// tb/tb_rob_ctrl.sv - self-checking bench for rob_ctrl with a queue-based reference model
module tb_rob_ctrl;

  localparam int N = 8;
  localparam int L = 3;
  localparam int M_RUN   = 0;
  localparam int M_WAIT  = 1;
  localparam int M_FLUSH = 2;

  logic         clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_alloc_req = 1'b0;
  logic         o_alloc_grant;
  logic [L-1:0] o_alloc_ticket;
  logic         o_full;
  logic         o_empty;
  logic [L:0]   o_count;
  logic         i_cmpl_sp_valid = 1'b0;
  logic [L-1:0] i_cmpl_sp_slot = '0;
  logic         i_cmpl_sp_exc = 1'b0;
  logic         i_cmpl_lp_valid = 1'b0;
  logic [L-1:0] i_cmpl_lp_slot = '0;
  logic         i_cmpl_lp_exc = 1'b0;
  logic [L-1:0] o_head_ptr;
  logic         o_commit_valid;
  logic         i_commit_stall = 1'b0;
  logic         o_exc_valid;
  logic [L-1:0] o_exc_slot;
  logic         i_exc_ack = 1'b0;
  logic         o_flush;

  always #5 clk = ~clk;

  rob_ctrl #(.NUM_ENTRIES(N), .LOG_NUM_ENTRIES(L)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_alloc_req(i_alloc_req), .o_alloc_grant(o_alloc_grant), .o_alloc_ticket(o_alloc_ticket),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .i_cmpl_sp_valid(i_cmpl_sp_valid), .i_cmpl_sp_slot(i_cmpl_sp_slot), .i_cmpl_sp_exc(i_cmpl_sp_exc),
    .i_cmpl_lp_valid(i_cmpl_lp_valid), .i_cmpl_lp_slot(i_cmpl_lp_slot), .i_cmpl_lp_exc(i_cmpl_lp_exc),
    .o_head_ptr(o_head_ptr), .o_commit_valid(o_commit_valid), .i_commit_stall(i_commit_stall),
    .o_exc_valid(o_exc_valid), .o_exc_slot(o_exc_slot), .i_exc_ack(i_exc_ack), .o_flush(o_flush)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
  endtask

  // Reference model: the ROB is an ordered list of live entries; head is the
  // first entry's slot (or the next ticket when empty).
  typedef struct {
    int slot;
    bit done;
    bit exc;
  } ent_t;

  ent_t q[$];
  int   m_next = 0;
  int   m_mode = M_RUN;
  int   e_head;
  bit   e_grant, e_commit, m_retire, m_fault;

  task automatic m_reset();
    q.delete();
    m_next = 0;
    m_mode = M_RUN;
  endtask

  always @(negedge clk) begin
    if (i_reset) m_reset();
    e_head   = (q.size() > 0) ? q[0].slot : m_next;
    e_commit = (m_mode == M_RUN) && (q.size() > 0) && q[0].done && !q[0].exc;
    e_grant  = i_alloc_req && (q.size() < N) && (m_mode == M_RUN);
    check("alloc_grant",  int'(o_alloc_grant),  int'(e_grant));
    check("alloc_ticket", int'(o_alloc_ticket), m_next);
    check("full",         int'(o_full),         int'(q.size() == N));
    check("empty",        int'(o_empty),        int'(q.size() == 0));
    check("count",        int'(o_count),        q.size());
    check("head_ptr",     int'(o_head_ptr),     e_head);
    check("commit_valid", int'(o_commit_valid), int'(e_commit));
    check("exc_valid",    int'(o_exc_valid),    int'(m_mode == M_WAIT));
    check("exc_slot",     int'(o_exc_slot),     e_head);
    check("flush",        int'(o_flush),        int'(m_mode == M_FLUSH));
    if (!i_reset) begin
      case (m_mode)
        M_RUN: begin
          foreach (q[k]) begin
            if (i_cmpl_sp_valid && q[k].slot == int'(i_cmpl_sp_slot)) begin
              q[k].done = 1'b1;
              q[k].exc  = q[k].exc | i_cmpl_sp_exc;
            end
            if (i_cmpl_lp_valid && q[k].slot == int'(i_cmpl_lp_slot)) begin
              q[k].done = 1'b1;
              q[k].exc  = q[k].exc | i_cmpl_lp_exc;
            end
          end
          m_retire = e_commit && !i_commit_stall;
          m_fault  = !m_retire && (q.size() > 0) && q[0].done && q[0].exc;
          if (m_retire) void'(q.pop_front());
          if (e_grant) begin
            q.push_back('{slot: m_next, done: 1'b0, exc: 1'b0});
            m_next = (m_next + 1) % N;
          end
          if (m_fault) m_mode = M_WAIT;
        end
        M_WAIT: if (i_exc_ack) m_mode = M_FLUSH;
        default: begin
          q.delete();
          m_next = 0;
          m_mode = M_RUN;
        end
      endcase
    end
  end

  task automatic drive(input bit req, input bit spv, input int sps, input bit spe,
                       input bit lpv, input int lps, input bit lpe,
                       input bit stall, input bit ack);
    @(posedge clk); #1;
    i_alloc_req     = req;
    i_cmpl_sp_valid = spv;
    i_cmpl_sp_slot  = L'(sps);
    i_cmpl_sp_exc   = spe;
    i_cmpl_lp_valid = lpv;
    i_cmpl_lp_slot  = L'(lps);
    i_cmpl_lp_exc   = lpe;
    i_commit_stall  = stall;
    i_exc_ack       = ack;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    i_reset = 1'b1;
    i_alloc_req = 0; i_cmpl_sp_valid = 0; i_cmpl_lp_valid = 0;
    i_cmpl_sp_exc = 0; i_cmpl_lp_exc = 0; i_commit_stall = 0; i_exc_ack = 0;
    @(negedge clk); #1;
    check("rst_empty", int'(o_empty), 1);
    check("rst_count", int'(o_count), 0);
    check("rst_head",  int'(o_head_ptr), 0);
    check("rst_flush", int'(o_flush) + int'(o_exc_valid) + int'(o_commit_valid) + int'(o_full), 0);
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    int found;

    // Fill from empty, ninth request refused
    do_reset();
    for (int i = 0; i < N; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("s1_grant", int'(o_alloc_grant), 1);
      check("s1_ticket", int'(o_alloc_ticket), i);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s1_full", int'(o_full), 1);
    check("s1_count", int'(o_count), 8);
    check("s1_refused", int'(o_alloc_grant), 0);

    // Out-of-order completion, in-order retirement
    do_reset();
    repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 2, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("s2_commit_early", int'(o_commit_valid), 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
    check("s2_commit0", int'(o_commit_valid), 1);
    check("s2_head0", int'(o_head_ptr), 0);
    idle();
    check("s2_head1", int'(o_head_ptr), 1);
    check("s2_commit1", int'(o_commit_valid), 1);
    idle();
    check("s2_head2", int'(o_head_ptr), 2);
    idle();
    check("s2_empty", int'(o_empty), 1);
    check("s2_commit_end", int'(o_commit_valid), 0);

    // Full with simultaneous retire: refused, then wrap-around ticket 0
    do_reset();
    repeat (N) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s3_commit", int'(o_commit_valid), 1);
    check("s3_nogrant", int'(o_alloc_grant), 0);
    check("s3_count8", int'(o_count), 8);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s3_count7", int'(o_count), 7);
    check("s3_grant", int'(o_alloc_grant), 1);
    check("s3_wrap", int'(o_alloc_ticket), 0);

    // sp and lp hit the same slot, lp carries the exception
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 0, 1, 0, 0);
    idle();
    check("s4_exc_valid", int'(o_exc_valid), 1);
    check("s4_exc_slot", int'(o_exc_slot), 0);
    check("s4_commit", int'(o_commit_valid), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();

    // Exception at slot 3, ack held off for 5 cycles
    do_reset();
    repeat (4) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 2, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 3, 1, 0, 0, 0, 0, 0);
    found = 0;
    for (int t = 0; t < 6 && found == 0; t++) begin
      idle();
      if (o_exc_valid) found = 1;
    end
    check("s5_exc_seen", found, 1);
    check("s5_exc_slot", int'(o_exc_slot), 3);
    for (int t = 0; t < 4; t++) begin
      drive(1, 1, 4, 0, 0, 0, 0, 0, 0);
      check("s5_exc_held", int'(o_exc_valid), 1);
      check("s5_no_grant", int'(o_alloc_grant), 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("s5_flush_not_yet", int'(o_flush), 0);
    idle();
    check("s5_flush", int'(o_flush), 1);
    check("s5_exc_drop", int'(o_exc_valid), 0);
    idle();
    check("s5_flush_once", int'(o_flush), 0);
    check("s5_count", int'(o_count), 0);
    check("s5_head", int'(o_head_ptr), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s5_ticket0", int'(o_alloc_ticket), 0);
    check("s5_grant", int'(o_alloc_grant), 1);

    // Unallocated completion ignored; stalled commit holds head
    do_reset();
    repeat (2) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 5, 0, 1, 7, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 1, 0);
    check("s6_no_commit", int'(o_commit_valid), 0);
    check("s6_no_exc", int'(o_exc_valid), 0);
    repeat (3) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("s6_stall_commit", int'(o_commit_valid), 1);
      check("s6_stall_head", int'(o_head_ptr), 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    check("s6_head1", int'(o_head_ptr), 1);
    check("s6_count1", int'(o_count), 1);

    // Randomized traffic against the model
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 9) < 6,
              $urandom_range(0, 1), $urandom_range(0, N - 1), $urandom_range(0, 11) == 0,
              $urandom_range(0, 1), $urandom_range(0, N - 1), $urandom_range(0, 11) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
